// File: rtl/phase_accumulator_scheduler_if.sv
// phase_accumulator_scheduler_if: tick/config inputs, shared-adder bus and published phase outputs.
interface phase_accumulator_scheduler_if #(
    parameter int NUM_VOICES = 8,
    parameter int VOICE_W    = 3,
    parameter int PHASE_W    = 18
);
    logic                  sample_tick;
    logic [NUM_VOICES-1:0] voice_enable;
    logic                  cfg_we;
    logic                  cfg_phase_clr;
    logic [VOICE_W-1:0]    cfg_voice;
    logic [PHASE_W-1:0]    cfg_increment;
    logic                  overrun_clr;
    logic [PHASE_W-1:0]    add_a;
    logic [PHASE_W-1:0]    add_b;
    logic                  add_c_in;
    logic [PHASE_W-1:0]    add_sum;
    logic                  add_c_out;
    logic                  phase_valid;
    logic [VOICE_W-1:0]    phase_voice;
    logic [PHASE_W-1:0]    phase_out;
    logic                  phase_wrap;
    logic                  frame_done;
    logic                  busy;
    logic                  overrun;

    modport master (
        input  sample_tick, voice_enable, cfg_we, cfg_phase_clr, cfg_voice, cfg_increment,
               overrun_clr, add_sum, add_c_out,
        output add_a, add_b, add_c_in, phase_valid, phase_voice, phase_out, phase_wrap,
               frame_done, busy, overrun
    );

    modport slave (
        output sample_tick, voice_enable, cfg_we, cfg_phase_clr, cfg_voice, cfg_increment,
               overrun_clr, add_sum, add_c_out,
        input  add_a, add_b, add_c_in, phase_valid, phase_voice, phase_out, phase_wrap,
               frame_done, busy, overrun
    );
endinterface

// File: rtl/phase_accumulator_scheduler.sv
// phase_accumulator_scheduler: steps every voice phase once per sample tick through one shared external adder.
module phase_accumulator_scheduler #(
    parameter int NUM_VOICES = 8,
    parameter int VOICE_W    = 3,
    parameter int PHASE_W    = 18
) (
    input logic clk,
    input logic reset_n,
    phase_accumulator_scheduler_if.master bus
);
    typedef enum logic {IDLE, RUN} state_t;

    state_t             state, state_n;
    logic [VOICE_W-1:0] cnt;
    logic [PHASE_W-1:0] phase [NUM_VOICES];
    logic [PHASE_W-1:0] inc [NUM_VOICES];
    logic               run, last, en;

    always_comb begin
        run = state == RUN;
        last = cnt == VOICE_W'(NUM_VOICES - 1);
        en = run && bus.voice_enable[cnt];
        state_n = run ? (last ? IDLE : RUN) : (bus.sample_tick ? RUN : IDLE);
        bus.busy = run;
        bus.add_a = run ? phase[cnt] : '0;
        bus.add_b = en ? inc[cnt] : '0;
        bus.add_c_in = 1'b0;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            cnt <= '0;
            bus.phase_valid <= 1'b0;
            bus.phase_voice <= '0;
            bus.phase_out <= '0;
            bus.phase_wrap <= 1'b0;
            bus.frame_done <= 1'b0;
            bus.overrun <= 1'b0;
            for (int i = 0; i < NUM_VOICES; i++) begin
                phase[i] <= '0;
                inc[i] <= '0;
            end
        end else begin
            state <= state_n;
            cnt <= (run && !last) ? cnt + 1'b1 : '0;
            bus.phase_valid <= en;
            if (en) begin
                bus.phase_out <= bus.add_sum;
                bus.phase_voice <= cnt;
                bus.phase_wrap <= bus.add_c_out;
            end
            bus.frame_done <= run && last;
            bus.overrun <= (run && bus.sample_tick) || (bus.overrun && !bus.overrun_clr);
            // A disabled voice adds 0, so writing add_sum back leaves its phase unchanged; a clear wins over the update.
            for (int i = 0; i < NUM_VOICES; i++) begin
                if (run && cnt == VOICE_W'(i))
                    phase[i] <= bus.add_sum;
                if (bus.cfg_phase_clr && bus.cfg_voice == VOICE_W'(i))
                    phase[i] <= '0;
                if (bus.cfg_we && bus.cfg_voice == VOICE_W'(i))
                    inc[i] <= bus.cfg_increment;
            end
        end
    end
endmodule

// File: tb/tb_phase_accumulator_scheduler.sv
// tb_phase_accumulator_scheduler: directed + randomized frames checked against a frame-level phase model.
module tb_phase_accumulator_scheduler;
    localparam int NV = 8;
    localparam int VW = 3;
    localparam int PW = 18;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int nchk = 0;
    int npass = 0;
    int nfail = 0;
    logic [PW-1:0] mphase [NV];
    logic [PW-1:0] minc [NV];
    logic mov = 1'b0;

    phase_accumulator_scheduler_if #(.NUM_VOICES(NV), .VOICE_W(VW), .PHASE_W(PW)) bus ();

    phase_accumulator_scheduler #(.NUM_VOICES(NV), .VOICE_W(VW), .PHASE_W(PW)) dut (
        .clk(clk),
        .reset_n(reset_n),
        .bus(bus.master)
    );

    always #5 clk = ~clk;

    // Behavioural stand-in for the shared 18-bit ripple adder.
    assign {bus.add_c_out, bus.add_sum} = {1'b0, bus.add_a} + {1'b0, bus.add_b} + {{PW{1'b0}}, bus.add_c_in};

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nchk++;
        assert (obs === exp) npass++;
        else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            chk("idle_outputs", 64'({bus.busy, bus.add_a, bus.add_b, bus.add_c_in, bus.phase_valid, bus.frame_done, bus.overrun}),
                64'({1'b0, {PW{1'b0}}, {PW{1'b0}}, 1'b0, 1'b0, 1'b0, mov}));
        end
    endtask

    task automatic cfg(input logic [VW-1:0] v, input logic [PW-1:0] i, input logic we, input logic clr);
        bus.cfg_voice = v;
        bus.cfg_increment = i;
        bus.cfg_we = we;
        bus.cfg_phase_clr = clr;
        if (clr) mphase[v] = '0;
        if (we) minc[v] = i;
        @(negedge clk);
        bus.cfg_we = 1'b0;
        bus.cfg_phase_clr = 1'b0;
    endtask

    task automatic clear_overrun();
        bus.overrun_clr = 1'b1;
        mov = 1'b0;
        @(negedge clk);
        bus.overrun_clr = 1'b0;
        chk("overrun_clr", 64'(bus.overrun), 64'(1'b0));
    endtask

    // Starts at a negedge (cycle T), returns at the negedge of the frame_done cycle T+1+NV.
    task automatic frame(input logic [NV-1:0] mask, input int xt = 0, input int cs = -1, input logic cwe = 1'b0,
                         input logic cclr = 1'b0, input logic [VW-1:0] cv = '0, input logic [PW-1:0] ci = '0);
        logic [PW-1:0] eo [NV];
        logic ew [NV];
        logic [PW-1:0] b;
        logic [PW:0] s;
        int nvalid = 0;
        int k;
        bus.sample_tick = 1'b1;
        bus.voice_enable = mask;
        for (int c = 1; c <= NV + 1; c++) begin
            @(negedge clk);
            bus.sample_tick = 1'b0;
            bus.cfg_we = 1'b0;
            bus.cfg_phase_clr = 1'b0;
            chk("busy", 64'(bus.busy), 64'(c <= NV));
            chk("frame_done", 64'(bus.frame_done), 64'(c == NV + 1));
            chk("overrun", 64'(bus.overrun), 64'(mov));
            if (c >= 2) begin
                k = c - 2;
                if (bus.phase_valid) nvalid++;
                chk("phase_valid", 64'(bus.phase_valid), 64'(mask[k]));
                if (mask[k]) begin
                    chk("phase_voice", 64'(bus.phase_voice), 64'(k));
                    chk("phase_out", 64'(bus.phase_out), 64'(eo[k]));
                    chk("phase_wrap", 64'(bus.phase_wrap), 64'(ew[k]));
                end
            end
            if (c <= NV) begin
                k = c - 1;
                b = mask[k] ? minc[k] : '0;
                chk("add_a", 64'(bus.add_a), 64'(mphase[k]));
                chk("add_b", 64'(bus.add_b), 64'(b));
                chk("add_c_in", 64'(bus.add_c_in), 64'(1'b0));
                s = {1'b0, mphase[k]} + {1'b0, b};
                eo[k] = s[PW-1:0];
                ew[k] = s[PW];
                mphase[k] = s[PW-1:0];
                if (k == cs) begin
                    bus.cfg_voice = cv;
                    bus.cfg_increment = ci;
                    bus.cfg_we = cwe;
                    bus.cfg_phase_clr = cclr;
                    if (cclr) mphase[cv] = '0;
                    if (cwe) minc[cv] = ci;
                end
                if (c == xt) begin
                    bus.sample_tick = 1'b1;
                    mov = 1'b1;
                end
            end
        end
        chk("valid_count", 64'(nvalid), 64'($countones(mask)));
    endtask

    initial begin
        bus.sample_tick = 1'b0;
        bus.voice_enable = '1;
        bus.cfg_we = 1'b0;
        bus.cfg_phase_clr = 1'b0;
        bus.cfg_voice = '0;
        bus.cfg_increment = '0;
        bus.overrun_clr = 1'b0;
        for (int i = 0; i < NV; i++) begin
            mphase[i] = '0;
            minc[i] = '0;
        end
        @(negedge clk);
        chk("reset_state", 64'({bus.busy, bus.phase_valid, bus.frame_done, bus.overrun, bus.phase_wrap, bus.phase_voice, bus.phase_out}), 64'(0));
        reset_n = 1'b1;
        idle(20);
        // Basic frame, then a second frame accumulates.
        cfg(3'd0, 18'h00100, 1'b1, 1'b0);
        cfg(3'd3, 18'h01000, 1'b1, 1'b0);
        frame(8'hFF);
        idle(2);
        frame(8'hFF);
        idle(1);
        // Wrap: park voice 2 at 0x3FFF0 then step by 0x20.
        cfg(3'd2, 18'h3FFF0, 1'b1, 1'b0);
        frame(8'hFF);
        cfg(3'd2, 18'h00020, 1'b1, 1'b0);
        frame(8'hFF);
        idle(1);
        // Disabled voice 0.
        cfg(3'd0, 18'h00010, 1'b1, 1'b1);
        frame(8'hFE);
        idle(1);
        frame(8'hFF);
        idle(1);
        // Overrun, clear, then back-to-back ticks on frame_done.
        frame(8'hFF, 4);
        idle(3);
        clear_overrun();
        idle(1);
        frame(8'hFF);
        frame(8'hFF);
        frame(8'hFF);
        idle(1);
        // Config collisions in the active slot.
        cfg(3'd1, 18'h00040, 1'b1, 1'b0);
        frame(8'hFF, 0, 1, 1'b1, 1'b0, 3'd1, 18'h00080);
        frame(8'hFF);
        frame(8'hFF, 0, 4, 1'b0, 1'b1, 3'd4, '0);
        frame(8'hFF);
        frame(8'hFF, 0, 5, 1'b1, 1'b1, 3'd6, 18'h12345);
        idle(1);
        // Randomized frames.
        for (int r = 0; r < 8; r++) begin
            cfg(3'($urandom_range(0, NV - 1)), PW'($urandom), 1'b1, 1'($urandom));
            cfg(3'($urandom_range(0, NV - 1)), PW'($urandom), 1'b1, 1'b0);
            frame(NV'($urandom), 0, $urandom_range(0, NV - 1), 1'($urandom), 1'($urandom),
                  3'($urandom_range(0, NV - 1)), PW'($urandom));
            idle($urandom_range(0, 2));
        end
        // Reset in the middle of a frame with overrun set.
        frame(8'hFF, 2);
        idle(1);
        bus.sample_tick = 1'b1;
        @(negedge clk);
        bus.sample_tick = 1'b0;
        repeat (4) @(negedge clk);
        reset_n = 1'b0;
        #1;
        chk("reset_async", 64'({bus.busy, bus.phase_valid, bus.frame_done, bus.overrun, bus.phase_wrap, bus.phase_voice}), 64'(0));
        chk("reset_async_out", 64'({bus.phase_out, bus.add_a, bus.add_b}), 64'(0));
        repeat (3) begin
            @(negedge clk);
            chk("reset_hold_valid", 64'({bus.phase_valid, bus.busy}), 64'(0));
        end
        reset_n = 1'b1;
        mov = 1'b0;
        for (int i = 0; i < NV; i++) begin
            mphase[i] = '0;
            minc[i] = '0;
        end
        idle(3);
        frame(8'hFF);
        idle(2);
        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end
endmodule

// File: doc/phase_accumulator_scheduler.md
Name: phase_accumulator_scheduler

Overview:
Time-multiplexes one shared 18-bit ripple full adder across NUM_VOICES oscillator phase accumulators. On each sample tick it steps every voice's phase by that voice's increment, one voice per clock, and publishes each new phase with a wrap flag. It sits between the synth's sample-rate timer and the waveform lookup stage. It owns the per-voice phase and increment registers and a small configuration port.

Parameters:
NUM_VOICES, 8, number of voices sharing the adder (2..16)
VOICE_W, 3, voice index width, equal to clog2(NUM_VOICES)
PHASE_W, 18, phase and increment width; must match the shared adder width

Ports:
clk  in  1  system clock; all state changes on the rising edge
reset_n  in  1  asynchronous, active-low reset
sample_tick  in  1  single-cycle pulse that requests one update frame
voice_enable  in  NUM_VOICES  per-voice enable mask, sampled in the voice's RUN slot
cfg_we  in  1  write cfg_increment into the increment register of cfg_voice
cfg_phase_clr  in  1  clear the phase of cfg_voice to 0
cfg_voice  in  VOICE_W  configuration target voice
cfg_increment  in  PHASE_W  new increment value
overrun_clr  in  1  clears the sticky overrun flag
add_a  out  PHASE_W  shared adder operand a (current phase)
add_b  out  PHASE_W  shared adder operand b (increment, or 0 if the voice is disabled)
add_c_in  out  1  shared adder carry in; tied to 0
add_sum  in  PHASE_W  shared adder sum (combinational, same cycle)
add_c_out  in  1  shared adder carry out
phase_valid  out  1  phase_out, phase_voice and phase_wrap are valid this cycle
phase_voice  out  VOICE_W  voice index of the published phase
phase_out  out  PHASE_W  updated phase
phase_wrap  out  1  the phase rolled over (add_c_out) on this update
frame_done  out  1  one-cycle pulse, coincident with the last phase_valid of a frame
busy  out  1  high while in RUN
overrun  out  1  sticky: a sample_tick arrived while busy

Behaviour:
- Reset (asynchronous, reset_n=0): state IDLE, voice counter 0. All phases and increments are 0. phase_valid, phase_voice, phase_out, phase_wrap, frame_done, busy and overrun are all 0. A reset during RUN aborts the frame and emits no further phase_valid pulses.
- FSM states are IDLE and RUN.
- IDLE → RUN on sample_tick=1. The counter loads 0.
- RUN, counter k: add_a = phase[k], add_b = voice_enable[k] ? inc[k] : 0, add_c_in = 0.
- At the edge ending slot k:
  - phase[k] ← add_sum.
  - If voice_enable[k]=1: register phase_out = add_sum, phase_voice = k, phase_wrap = add_c_out, and phase_valid = 1 for the next cycle.
  - If voice_enable[k]=0: phase is unchanged and phase_valid = 0.
- Counter increments; when k = NUM_VOICES-1, the FSM returns to IDLE and frame_done = 1 for the next cycle, regardless of the enable mask.
- Latency: a tick in cycle T puts voice 0 on the adder in T+1. Voice k's result is visible in cycle T+2+k. frame_done is high in T+1+NUM_VOICES.
- Frame length is fixed at NUM_VOICES cycles. The minimum tick spacing is NUM_VOICES+1 cycles.
- A tick is accepted in the cycle frame_done is high, because the FSM is already IDLE.
- sample_tick while busy is ignored (no queueing) and sets overrun=1.
- overrun_clr clears overrun. If a tick-while-busy and overrun_clr occur in the same cycle, set wins.
- When busy=0, add_a, add_b and add_c_in are driven to 0.
- cfg_we takes effect at the clock edge.
  - If cfg_voice equals the voice in the current RUN slot, that slot uses the old increment; the new value applies from the next frame.
- cfg_phase_clr clears phase[cfg_voice] at the edge.
  - If it targets the voice being updated in the same cycle, the clear wins: phase becomes 0, phase_out shows add_sum, and phase_wrap is as computed.
  - cfg_we and cfg_phase_clr may be asserted together; both take effect.
- Arithmetic is modulo 2^PHASE_W with no saturation; wrap is exactly the adder carry out.
- cfg_voice ≥ NUM_VOICES: the write is ignored.

Test Plan:
- Reset then idle: release reset_n, no tick for 20 cycles → all outputs 0, add_a/add_b = 0, busy = 0.
- Basic frame: inc[0]=0x00100, inc[3]=0x01000, all enabled, tick at T → phase_valid in T+2..T+9. Voice 0 gives phase_out=0x00100; voice 3 gives 0x01000; other voices give 0x00000; frame_done is high at T+9. After a second tick, voice 0 gives 0x00200.
- Wrap: inc[2]=0x20, advance voice 2 to phase 0x3FFF0 via repeated frames, tick → voice 2 phase_out=0x00010 with phase_wrap=1; all other voices have phase_wrap=0.
- Disabled voice: voice_enable=0xFE, inc[0]=0x10, tick → no phase_valid for voice 0 and phase[0] stays 0. Only 7 phase_valid pulses occur, and frame_done still fires at T+9.
- Overrun and back-to-back ticks:
  - Tick at T and again at T+4 → the second tick is ignored, overrun=1, and only one frame runs.
  - overrun_clr at T+12 → overrun=0.
  - Tick exactly at T+9 (frame_done cycle) → a new frame starts and overrun stays 0.
- Config collisions and reset:
  - cfg_we to voice 1 (inc 0x40 → 0x80) during voice 1's slot → this frame adds 0x40, the next adds 0x80.
  - cfg_phase_clr on voice 4 during its slot → phase[4]=0 afterwards.
  - reset_n low at T+5 → outputs clear immediately and no further phase_valid pulses.
